// File: rtl/uart_tx_frame_if.sv
// Parallel-side handshake and serial line of the UART transmit framer.
// The system side drives data and config; the framer returns TX_OUT and Busy.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA,
        output Data_Valid,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  Data_Valid,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output Busy
    );

endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, stop; one bit per CLK.
// Optional macro UART_TX_HOLD_REG_EN adds a one-entry holding register for gapless frames.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input logic            CLK,
    input logic            RST,
    uart_tx_frame_if.slave bus
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  pen_q;
    logic                  pen_d;
    logic                  ptyp_q;
    logic                  ptyp_d;
    logic                  tx_q;
    logic                  tx_d;
    logic                  busy_q;
    logic                  busy_d;
    logic                  accept;

`ifdef UART_TX_HOLD_REG_EN
    logic [DATA_WIDTH-1:0] hold_data_q;
    logic [DATA_WIDTH-1:0] hold_data_d;
    logic                  hold_pen_q;
    logic                  hold_pen_d;
    logic                  hold_ptyp_q;
    logic                  hold_ptyp_d;
    logic                  hold_full_q;
    logic                  hold_full_d;
    logic                  direct;

    // A request is taken whenever the holding slot is free.
    assign accept = bus.Data_Valid && !hold_full_q;

    // Bypass the slot when the shifter can start on the very next edge.
    assign direct = (state_q == IDLE) ||
                    ((state_q == STOP) && !hold_full_q);
`else
    // Without a holding slot only an idle framer takes a request.
    assign accept = bus.Data_Valid && (state_q == IDLE);
`endif

    // State register: FSM, counter, latched frame and registered outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            pen_q       <= 1'b0;
            ptyp_q      <= 1'b0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
`ifdef UART_TX_HOLD_REG_EN
            hold_data_q <= '0;
            hold_pen_q  <= 1'b0;
            hold_ptyp_q <= 1'b0;
            hold_full_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            pen_q       <= pen_d;
            ptyp_q      <= ptyp_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
`ifdef UART_TX_HOLD_REG_EN
            hold_data_q <= hold_data_d;
            hold_pen_q  <= hold_pen_d;
            hold_ptyp_q <= hold_ptyp_d;
            hold_full_q <= hold_full_d;
`endif
        end
    end

    // Next state: frame sequencing and capture of the frame to send.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        pen_d       = pen_q;
        ptyp_d      = ptyp_q;
`ifdef UART_TX_HOLD_REG_EN
        hold_data_d = hold_data_q;
        hold_pen_d  = hold_pen_q;
        hold_ptyp_d = hold_ptyp_q;
        hold_full_d = hold_full_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d  = bus.P_DATA;
                    pen_d   = bus.PAR_EN;
                    ptyp_d  = bus.PAR_TYP;
                    state_d = START;
                end
            end
            START: begin
                cnt_d   = '0;
                state_d = DATA;
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = pen_q ? PARITY : STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PARITY: begin
                state_d = STOP;
            end
            STOP: begin
`ifdef UART_TX_HOLD_REG_EN
                if (hold_full_q) begin
                    data_d      = hold_data_q;
                    pen_d       = hold_pen_q;
                    ptyp_d      = hold_ptyp_q;
                    hold_full_d = 1'b0;
                    state_d     = START;
                end else if (accept) begin
                    data_d  = bus.P_DATA;
                    pen_d   = bus.PAR_EN;
                    ptyp_d  = bus.PAR_TYP;
                    state_d = START;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
`ifdef UART_TX_HOLD_REG_EN
        if (accept && !direct) begin
            hold_data_d = bus.P_DATA;
            hold_pen_d  = bus.PAR_EN;
            hold_ptyp_d = bus.PAR_TYP;
            hold_full_d = 1'b1;
        end
`endif
    end

    // Outputs: pick the line level for the upcoming state so TX_OUT comes from a flop.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[cnt_d];
            PARITY:  tx_d = ptyp_d ? ~^data_d : ^data_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
`ifdef UART_TX_HOLD_REG_EN
        busy_d = hold_full_d;
`else
        busy_d = (state_d != IDLE);
`endif
    end

    assign bus.TX_OUT = tx_q;
    assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame with a bit-level scoreboard.
// Honours UART_TX_HOLD_REG_EN for the gapless-frame expectations.
module tb_uart_tx_frame;

    logic CLK;
    logic RST;
    int   checks;
    int   errors;

    logic qtx[$];
    logic qbusy[$];

    uart_tx_frame_if #(.DATA_WIDTH(8)) bus ();

    uart_tx_frame #(.DATA_WIDTH(8)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input logic pe,
                              input logic pt);
        int ones;
        ones = 0;
        qtx.push_back(1'b0);
        qbusy.push_back(1'b1);
        for (int i = 0; i < 8; i++) begin
            qtx.push_back(d[i]);
            qbusy.push_back(1'b1);
            if (d[i]) ones++;
        end
        if (pe) begin
            qtx.push_back(((ones % 2) == 1) ? !pt : pt);
            qbusy.push_back(1'b1);
        end
        qtx.push_back(1'b1);
        qbusy.push_back(1'b1);
    endtask

    task automatic start(input logic [7:0] d, input logic pe,
                         input logic pt, input bit keep);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_TYP    = pt;
        bus.Data_Valid = 1'b1;
        @(negedge CLK);
        if (!keep) bus.Data_Valid = 1'b0;
    endtask

    task automatic run_queue(input int pulse_at, input int rst_at,
                             input int drop_at);
        int   i;
        logic et;
        logic eb;
        i = 0;
        while (qtx.size() > 0) begin
            et = qtx.pop_front();
            eb = qbusy.pop_front();
            check($sformatf("tx[%0d]", i), bus.TX_OUT, et);
`ifndef UART_TX_HOLD_REG_EN
            check($sformatf("busy[%0d]", i), bus.Busy, eb);
`endif
            if (i == pulse_at) begin
`ifdef UART_TX_HOLD_REG_EN
                check("busy_at_pulse", bus.Busy, 1'b0);
                push_frame(8'h3C, 1'b0, 1'b1);
`else
                check("busy_at_pulse", bus.Busy, 1'b1);
`endif
                bus.P_DATA     = 8'h3C;
                bus.PAR_EN     = 1'b0;
                bus.PAR_TYP    = 1'b1;
                bus.Data_Valid = 1'b1;
            end
            if (i == drop_at) bus.Data_Valid = 1'b0;
            if (i == rst_at) begin
                RST = 1'b0;
                #1;
                check("tx_async_rst", bus.TX_OUT, 1'b1);
                check("busy_async_rst", bus.Busy, 1'b0);
                qtx.delete();
                qbusy.delete();
            end
            i++;
            @(negedge CLK);
        end
        check("tx_idle", bus.TX_OUT, 1'b1);
        check("busy_idle", bus.Busy, 1'b0);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        RST            = 1'b0;
        bus.P_DATA     = '0;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_TYP    = 1'b0;

        // reset state
        @(negedge CLK);
        @(negedge CLK);
        check("rst_tx", bus.TX_OUT, 1'b1);
        check("rst_busy", bus.Busy, 1'b0);
        RST = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        check("idle_tx", bus.TX_OUT, 1'b1);
        check("idle_busy", bus.Busy, 1'b0);

        // 1: A5 with even parity
        push_frame(8'hA5, 1'b1, 1'b0);
        start(8'hA5, 1'b1, 1'b0, 1'b0);
        run_queue(-1, -1, -1);

        // 2: 01 with odd then even parity
        push_frame(8'h01, 1'b1, 1'b1);
        start(8'h01, 1'b1, 1'b1, 1'b0);
        run_queue(-1, -1, -1);
        push_frame(8'h01, 1'b1, 1'b0);
        start(8'h01, 1'b1, 1'b0, 1'b0);
        run_queue(-1, -1, -1);

        // 3: FF without parity
        push_frame(8'hFF, 1'b0, 1'b0);
        start(8'hFF, 1'b0, 1'b0, 1'b0);
        run_queue(-1, -1, -1);

        // 4: request mid-frame with 3C
        push_frame(8'hA5, 1'b1, 1'b0);
        start(8'hA5, 1'b1, 1'b0, 1'b0);
        run_queue(3, -1, 4);

        // 5: asynchronous reset in the 4th data cycle, then 55
        push_frame(8'h55, 1'b0, 1'b0);
        start(8'h55, 1'b0, 1'b0, 1'b0);
        run_queue(-1, 4, -1);
        RST = 1'b1;
        @(negedge CLK);
        check("post_rst_tx", bus.TX_OUT, 1'b1);
        check("post_rst_busy", bus.Busy, 1'b0);
        push_frame(8'h55, 1'b1, 1'b1);
        start(8'h55, 1'b1, 1'b1, 1'b0);
        run_queue(-1, -1, -1);

        // 6: Data_Valid held across A5 then 5A
        push_frame(8'hA5, 1'b0, 1'b0);
`ifndef UART_TX_HOLD_REG_EN
        qtx.push_back(1'b1);
        qbusy.push_back(1'b0);
`endif
        push_frame(8'h5A, 1'b0, 1'b0);
        start(8'hA5, 1'b0, 1'b0, 1'b1);
        bus.P_DATA = 8'h5A;
`ifdef UART_TX_HOLD_REG_EN
        run_queue(-1, -1, 1);
`else
        run_queue(-1, -1, 11);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmitter that pairs with the UART receive path. It takes a parallel byte with a valid strobe, then serializes it one bit per CLK cycle as a frame: start, data LSB-first, optional parity, stop. CLK is the TX baud clock, so one bit equals one CLK cycle. Sits between the system-side TX FIFO/controller and the serial pad.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (legal range 5..9)

Ports:
CLK  input  1  TX baud clock, rising-edge
RST  input  1  asynchronous active-low reset
P_DATA  input  DATA_WIDTH  parallel data to send
Data_Valid  input  1  request to send P_DATA; sampled on CLK rising edge
PAR_EN  input  1  1 = insert parity bit
PAR_TYP  input  1  0 = even parity, 1 = odd parity
TX_OUT  output  1  serial line, registered, idles high
Busy  output  1  registered; 1 = Data_Valid is ignored this cycle

Behaviour:
- Reset (RST=0, asynchronous, at any time including mid-frame):
  - TX_OUT=1, Busy=0, FSM=IDLE, bit counter=0, internal data/config registers=0.
  - On release, the block waits in IDLE; no partial frame resumes.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, Busy=0.
  - Data_Valid=1 at edge N latches P_DATA, PAR_EN and PAR_TYP, and goes to START.
  - TX_OUT=0 and Busy=1 are visible after edge N, i.e. 1-cycle latency.
- START: one cycle, TX_OUT=0, then DATA.
- DATA:
  - DATA_WIDTH cycles; TX_OUT = latched data bit[i], i = 0..DATA_WIDTH-1, LSB first.
  - Counter wraps to 0 on exit.
  - Goes to PARITY if latched PAR_EN=1, else STOP.
- PARITY: one cycle, TX_OUT = ^data when PAR_TYP=0, ~^data when PAR_TYP=1. Computed from latched data, never live P_DATA.
- STOP: one cycle, TX_OUT=1, Busy=1. Next state IDLE, with Busy=0 from the following edge.
- Frame length = 2 + DATA_WIDTH + PAR_EN cycles.
- Minimum inter-frame gap (base build) is 1 idle-high cycle.
- Data_Valid while Busy=1 is dropped, with no side effect.
- P_DATA, PAR_EN and PAR_TYP changing mid-frame have no effect on the current frame.
- Data_Valid held high continuously: a new frame is accepted in each IDLE cycle, giving back-to-back frames separated by 1 idle cycle.
- TX_OUT must be glitch-free: driven directly from a flop, not from a combinational mux.

Optional Feature:
Macro UART_TX_HOLD_REG_EN.
- Defined:
  - Adds a one-entry holding register (data plus PAR_EN/PAR_TYP) in front of the shift logic.
  - Busy = holding register full.
  - Data_Valid with Busy=0 loads the holding register even while a frame is in progress.
  - When STOP ends with the holding register full, the FSM goes directly to START with no idle cycle, and the holding register empties. Busy drops on that same edge.
  - From IDLE, a load goes to START on the next edge, with the holding register passed straight through, so latency is unchanged at 1 cycle.
  - Reset clears the holding register.
- Undefined: behaviour exactly as in Behaviour, with no holding register and Busy = frame in progress.

Test Plan:
1. Reset, then P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, one-cycle Data_Valid -> TX_OUT over 11 cycles = 0,1,0,1,0,0,1,0,1,0,1. Busy=1 for exactly those 11 cycles, then TX_OUT=1, Busy=0.
2. P_DATA=8'h01, PAR_EN=1: PAR_TYP=1 -> parity bit 0; PAR_TYP=0 -> parity bit 1. Frame length 11 in both cases.
3. P_DATA=8'hFF, PAR_EN=0 -> 10-cycle frame 0, then eight 1s, then 1. No parity cycle.
4. Data_Valid pulsed with P_DATA=8'h3C during DATA of a frame carrying 8'hA5 -> 8'h3C never transmitted. Only 8'hA5 appears, and Busy was 1 at the pulse.
5. RST pulled low in the 4th DATA cycle -> TX_OUT=1 and Busy=0 immediately, without waiting for CLK. After release, a new 8'h55 frame is sent correctly from start.
6. Data_Valid held high with 8'hA5 then 8'h5A -> base build: exactly 1 idle-high cycle between frames. With UART_TX_HOLD_REG_EN: zero idle cycles, so the STOP bit of frame 1 is directly followed by the START bit of frame 2.
